// File: rtl/tune_pkg.sv
// Shared tune identifiers, priority helpers and tune lengths for the tune
// arbiter and the music player.
package tune_pkg;

    typedef enum logic [1:0] {
        TUNE_None     = 2'd0,
        TUNE_BTN      = 2'd1,
        TUNE_Victory  = 2'd2,
        TUNE_GameOver = 2'd3
    } TUNE_ID;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } arb_state_t;

    localparam int unsigned TIMER_W  = 32;
    localparam int unsigned BTN_DIV  = 20;
    localparam int unsigned LONG_NUM = 7;
    localparam int unsigned LONG_DEN = 4;

    // Encoding order doubles as priority rank: None < BTN < Victory < GameOver.
    function automatic logic [1:0] tune_rank(input TUNE_ID id);
        return id;
    endfunction

    // req bits: [2] GameOver, [1] Victory, [0] BTN.
    function automatic TUNE_ID tune_pick(input logic [2:0] req);
        if (req[2]) return TUNE_GameOver;
        if (req[1]) return TUNE_Victory;
        if (req[0]) return TUNE_BTN;
        return TUNE_None;
    endfunction

    function automatic logic [TIMER_W-1:0] tune_len(input TUNE_ID id,
                                                    input int unsigned cps,
                                                    input int unsigned guard);
        logic [63:0] w_len;
        case (id)
            TUNE_BTN:                    w_len = 64'(cps) / 64'(BTN_DIV) + 64'(guard);
            TUNE_Victory, TUNE_GameOver: w_len = 64'(cps) * 64'(LONG_NUM) / 64'(LONG_DEN) + 64'(guard);
            default:                     w_len = '0;
        endcase
        return w_len[TIMER_W-1:0];
    endfunction

endpackage

// File: rtl/tune_busy_timer.sv
// Countdown that tracks how long the current tune is deemed to be playing;
// expired is high whenever the count has reached zero.
module tune_busy_timer
    import tune_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               clear,
    output logic               expired
);

    logic [TIMER_W-1:0] r_count;

    // Holds at zero rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - TIMER_W'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule

// File: rtl/tune_request_arbiter.sv
// Arbitrates button/victory/game-over tune requests into single new_tune pulses.
// Define TUNE_ARB_PREEMPT_EN to let an outranking request cut the playing tune.
module tune_request_arbiter
    import tune_pkg::*;
#(
    parameter int unsigned CLK_PER_SEC  = 1000000,
    parameter int unsigned GUARD_CYCLES = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   req_btn,
    input  logic   req_victory,
    input  logic   req_gameover,
    input  logic   mute,
    output logic   new_tune,
    output TUNE_ID tune_id,
    output logic   busy,
    output logic   dropped
);

    arb_state_t r_state;
    logic [1:0] r_pend;     // [1] GameOver, [0] Victory
    logic       r_new_tune;
    TUNE_ID     r_tune_id;
    logic       r_dropped;
    logic       r_armed;

    arb_state_t         w_state_next;
    logic [1:0]         w_pend_next;
    logic               w_new_tune_next;
    TUNE_ID             w_tune_id_next;
    logic               w_dropped_next;
    logic [2:0]         w_live;
    logic [2:0]         w_cand;
    TUNE_ID             w_best;
    TUNE_ID             w_best_live;
    logic               w_preempt;
    logic               w_issue;
    logic               w_mute_stop;
    logic               w_expired;
    logic [TIMER_W-1:0] w_load_value;

    // r_armed masks requests on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pend     <= '0;
            r_new_tune <= 1'b0;
            r_tune_id  <= TUNE_None;
            r_dropped  <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pend     <= w_pend_next;
            r_new_tune <= w_new_tune_next;
            r_tune_id  <= w_tune_id_next;
            r_dropped  <= w_dropped_next;
            r_armed    <= 1'b1;
        end
    end

    always_comb begin
        w_live      = {req_gameover, req_victory, req_btn} & {3{r_armed & ~mute}};
        w_cand      = w_live | {r_pend, 1'b0};
        w_best      = tune_pick(w_cand);
        w_best_live = tune_pick(w_live);
`ifdef TUNE_ARB_PREEMPT_EN
        w_preempt   = (r_state == PLAY) && (tune_rank(w_best_live) > tune_rank(r_tune_id));
`else
        w_preempt   = 1'b0;
`endif
        w_issue     = ~mute && (((r_state == IDLE) && (w_cand != '0)) || w_preempt);
        w_mute_stop = mute && (r_state == PLAY);

        w_state_next    = r_state;
        w_new_tune_next = w_issue | w_mute_stop;
        w_tune_id_next  = r_tune_id;
        w_pend_next     = r_pend | w_live[2:1];
        // Long tunes merge into an existing pending flag; BTN is lost unless it is the one issued.
        w_dropped_next  = (|(w_live[2:1] & r_pend)) ||
                          (w_live[0] && !(w_issue && (w_best == TUNE_BTN)));

        if (w_issue) begin
            w_tune_id_next = w_best;
            if (w_best == TUNE_GameOver) w_pend_next[1] = 1'b0;
            if (w_best == TUNE_Victory)  w_pend_next[0] = 1'b0;
        end

        if (mute) begin
            w_state_next = IDLE;
            w_pend_next  = '0;
            if (w_mute_stop) w_tune_id_next = TUNE_None;
        end else if (w_issue) begin
            w_state_next = PLAY;
        end else if ((r_state == PLAY) && w_expired) begin
            w_state_next = IDLE;
        end

        w_load_value = tune_len(w_best, CLK_PER_SEC, GUARD_CYCLES);
    end

    tune_busy_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_issue),
        .load_value (w_load_value),
        .clear      (w_mute_stop),
        .expired    (w_expired)
    );

    assign new_tune = r_new_tune;
    assign tune_id  = r_tune_id;
    assign busy     = (r_state == PLAY);
    assign dropped  = r_dropped;

endmodule

// File: tb/tb_tune_request_arbiter.sv
// Scoreboard bench for tune_request_arbiter: a time-based reference model
// predicts pulses into queues, a negedge monitor consumes and compares them.
module tb_tune_request_arbiter;
    import tune_pkg::*;

    localparam int LEN_BTN  = 58;     // 1000/20 + 8
    localparam int LEN_LONG = 1758;   // 1000*7/4 + 8
`ifdef TUNE_ARB_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   req_btn = 1'b0;
    logic   req_victory = 1'b0;
    logic   req_gameover = 1'b0;
    logic   mute = 1'b0;
    logic   new_tune;
    TUNE_ID tune_id;
    logic   busy;
    logic   dropped;

    tune_request_arbiter #(
        .CLK_PER_SEC  (1000),
        .GUARD_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_btn      (req_btn),
        .req_victory  (req_victory),
        .req_gameover (req_gameover),
        .mute         (mute),
        .new_tune     (new_tune),
        .tune_id      (tune_id),
        .busy         (busy),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int id; } ev_t;
    ev_t tune_q[$];
    int  drop_q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model: ids ranked 0 None, 1 BTN, 2 Victory, 3 GameOver.
    int cyc = 0;
    bit m_play = 1'b0;
    int m_end = 0;       // last cycle the current tune counts as busy
    int m_cur = 0;
    bit m_pend[4];
    bit m_armed = 1'b0;
    int m_last = 0;
    bit m_busy = 1'b0;

    task automatic model_reset();
        tune_q.delete();
        drop_q.delete();
        m_play = 1'b0;
        for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
        m_armed = 1'b0;
        m_last = 0;
        m_busy = 1'b0;
        cyc = 0;
    endtask

    task automatic model_step();
        int c = cyc;
        bit live[4];
        int best_live = 0;
        int best;
        bit drop = 1'b0;
        live[0] = 1'b0;
        live[1] = req_btn;
        live[2] = req_victory;
        live[3] = req_gameover;
        if (!m_armed || mute) for (int i = 1; i < 4; i++) live[i] = 1'b0;
        m_armed = 1'b1;
        if (mute) begin
            for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
            if (m_play) begin
                m_play = 1'b0;
                m_last = 0;
                tune_q.push_back('{cyc: c + 1, id: 0});
            end
        end else begin
            for (int i = 1; i < 4; i++) if (live[i]) best_live = i;
            if (m_play && !(PREEMPT && best_live > m_cur)) begin
                if (live[1]) drop = 1'b1;
                for (int i = 2; i < 4; i++) if (live[i]) begin
                    if (m_pend[i]) drop = 1'b1;
                    m_pend[i] = 1'b1;
                end
                if (c == m_end) m_play = 1'b0;
            end else begin
                best = best_live;
                for (int i = 2; i < 4; i++) if (m_pend[i] && i > best) best = i;
                if (best != 0) begin
                    if (live[1] && best != 1) drop = 1'b1;
                    for (int i = 2; i < 4; i++) if (live[i]) begin
                        if (m_pend[i]) drop = 1'b1;
                        if (i != best) m_pend[i] = 1'b1;
                    end
                    m_pend[best] = 1'b0;
                    m_play = 1'b1;
                    m_cur = best;
                    m_end = c + 1 + ((best == 1) ? LEN_BTN : LEN_LONG);
                    m_last = best;
                    tune_q.push_back('{cyc: c + 1, id: best});
                end
            end
            if (drop) drop_q.push_back(c + 1);
        end
        cyc = c + 1;
        m_busy = m_play;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Monitor: compares on every DUT pulse, and flags predicted pulses that never came.
    always @(negedge clk) begin
        if (rst_n) begin
            ev_t ev;
            int  dc;
            checks++;
            if (busy !== m_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, m_busy);
            end
            checks++;
            if (int'(tune_id) != m_last) begin
                errors++;
                $display("FAIL tune_id_hold cyc=%0d got=%0d want=%0d", cyc, int'(tune_id), m_last);
            end
            while (tune_q.size() > 0 && tune_q[0].cyc < cyc) begin
                ev = tune_q.pop_front();
                checks++;
                errors++;
                $display("FAIL new_tune_missing got=none want=cyc %0d id %0d", ev.cyc, ev.id);
            end
            while (drop_q.size() > 0 && drop_q[0] < cyc) begin
                dc = drop_q.pop_front();
                checks++;
                errors++;
                $display("FAIL dropped_missing got=none want=cyc %0d", dc);
            end
            if (new_tune === 1'b1) begin
                checks++;
                if (tune_q.size() == 0) begin
                    errors++;
                    $display("FAIL new_tune_unexpected cyc=%0d got id %0d want=no pulse", cyc, int'(tune_id));
                end else begin
                    ev = tune_q.pop_front();
                    if (ev.cyc != cyc || ev.id != int'(tune_id)) begin
                        errors++;
                        $display("FAIL new_tune got=cyc %0d id %0d want=cyc %0d id %0d",
                                 cyc, int'(tune_id), ev.cyc, ev.id);
                    end
                end
            end
            if (dropped === 1'b1) begin
                checks++;
                if (drop_q.size() == 0) begin
                    errors++;
                    $display("FAIL dropped_unexpected cyc=%0d got=1 want=0", cyc);
                end else begin
                    dc = drop_q.pop_front();
                    if (dc != cyc) begin
                        errors++;
                        $display("FAIL dropped got=cyc %0d want=cyc %0d", cyc, dc);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int k);
        while (cyc < k) step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        checks++;
        if (new_tune !== 1'b0 || tune_id !== TUNE_None || busy !== 1'b0 || dropped !== 1'b0) begin
            errors++;
            $display("FAIL %s got nt=%b id=%0d busy=%b drop=%b want all zero",
                     tag, new_tune, int'(tune_id), busy, dropped);
        end
    endtask

    task automatic do_reset();
        req_btn = 1'b0; req_victory = 1'b0; req_gameover = 1'b0; mute = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset_state");
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic pulse(input bit b, input bit v, input bit g);
        req_btn = b; req_victory = v; req_gameover = g;
        step();
        req_btn = 1'b0; req_victory = 1'b0; req_gameover = 1'b0;
    endtask

    initial begin
        int n;
        // Button tune; a GameOver on the reset-release cycle must be ignored.
        do_reset();
        pulse(1'b0, 1'b0, 1'b1);
        goto_cyc(10);
        pulse(1'b1, 1'b0, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            step();
        end
        checks++;
        if (n != LEN_BTN + 1) begin
            errors++;
            $display("FAIL btn_busy_len got=%0d want=%0d", n, LEN_BTN + 1);
        end
        repeat (20) step();

        // Simultaneous Victory + BTN: Victory issued, BTN dropped.
        do_reset();
        goto_cyc(5);
        pulse(1'b1, 1'b1, 1'b0);
        checks++;
        if (new_tune !== 1'b1 || tune_id !== TUNE_Victory || dropped !== 1'b1) begin
            errors++;
            $display("FAIL vic_btn_same got nt=%b id=%0d drop=%b want 1/%0d/1",
                     new_tune, int'(tune_id), dropped, int'(TUNE_Victory));
        end
        repeat (1800) step();

        // Victory then GameOver 100 cycles later: pend or preempt.
        do_reset();
        goto_cyc(1);
        pulse(1'b0, 1'b1, 1'b0);
        goto_cyc(101);
        pulse(1'b0, 1'b0, 1'b1);
        repeat (3700) step();

        // Mute during play discards pending work and blocks requests.
        do_reset();
        goto_cyc(1);
        pulse(1'b0, 1'b1, 1'b0);
        goto_cyc(150);
        pulse(1'b0, 1'b1, 1'b0);
        goto_cyc(200);
        mute = 1'b1;
        goto_cyc(300);
        pulse(1'b1, 1'b0, 1'b0);
        goto_cyc(350);
        mute = 1'b0;
        repeat (100) step();

        // Reset mid-tune with a pending GameOver; nothing may follow.
        do_reset();
        goto_cyc(1);
        pulse(1'b0, 1'b1, 1'b0);
        goto_cyc(50);
        pulse(1'b0, 1'b1, 1'b1);
        goto_cyc(500);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset_mid_tune");
        step();
        step();
        rst_n = 1'b1;
        repeat (2000) step();

        // Randomised traffic with occasional mute windows and bursts.
        do_reset();
        for (int i = 0; i < 15000; i++) begin
            req_btn      = ($urandom_range(0, 39) == 0);
            req_victory  = ($urandom_range(0, 599) == 0);
            req_gameover = ($urandom_range(0, 899) == 0);
            if ($urandom_range(0, 499) == 0) begin
                req_btn = 1'b1; req_victory = 1'b1; req_gameover = 1'b1;
            end
            if (mute) begin
                if ($urandom_range(0, 59) == 0) mute = 1'b0;
            end else if ($urandom_range(0, 2999) == 0) begin
                mute = 1'b1;
            end
            step();
        end
        req_btn = 1'b0; req_victory = 1'b0; req_gameover = 1'b0; mute = 1'b0;
        repeat (5) step();
        checks++;
        if (tune_q.size() != 0 || drop_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect got tune=%0d drop=%0d want 0/0", tune_q.size(), drop_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
